shift_normalizer: RTL
=====================

Name: shift_normalizer

Overview:
- Multi-cycle normalizer; the inverse of the CPU's combinational shifter.
- Given an operand, it shifts one bit per cycle until a leading one (left mode) or trailing one (right mode) reaches the edge.
- Returns the normalized value and the shift count, so that shifting the original operand by count in the same direction reproduces out.
- Sits beside the ALU. Used for leading/trailing-zero count and normalize instructions, under start/busy/done handshake from the control unit.

Parameters:
- WIDTH, 16, operand width in bits.
- CNT_W, 5, count width; must hold the value WIDTH (ceil(log2(WIDTH+1))).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- left  input  1  1 = normalize toward MSB (shift left); 0 = toward LSB (shift right); latched with start.
- a  input  WIDTH  operand; latched with start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle completion pulse.
- out  output  WIDTH  normalized result.
- count  output  CNT_W  number of single-bit shifts applied.
- zero  output  1  operand was all-zero.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, out=0, count=0, zero=0.
  - Internal shift register, counter and direction cleared.
  - Reset asserted mid-operation aborts immediately; no done pulse is issued for the aborted request.
- States: IDLE, SHIFT, DONE. Registered outputs, Moore style: busy=(state==SHIFT), done=(state==DONE).
- IDLE:
  - start=1 at a clock edge: latch a into sreg, left into dir, clear cnt, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, evaluated every edge in priority order:
  1. sreg==0: out=0, count=WIDTH, zero=1, go to DONE.
  2. edge bit set (dir=1: sreg[WIDTH-1]; dir=0: sreg[0]): out=sreg, count=cnt, zero=0, go to DONE.
  3. Otherwise: sreg shifts one bit toward dir with zero fill, cnt=cnt+1, stay in SHIFT.
- DONE: lasts exactly one cycle, then unconditionally returns to IDLE.
- Latency: start high in cycle 0 -> done high in cycle n+2, where n = shift count. All-zero operand -> done in cycle 2.
- out, count and zero update only on the edge entering DONE. They hold their value until the next completion, not merely until the next start.
- start while busy or in DONE is ignored; it is not queued. start must be re-asserted in IDLE.
- a and left may change freely after the start edge; only the latched copies are used.
- cnt never exceeds WIDTH-1 during SHIFT, since a nonzero operand always terminates within WIDTH-1 shifts. No wrap-around is possible.
- Invariants at done:
  - Nonzero operand, left: out == a << count and out[WIDTH-1]==1.
  - Nonzero operand, right: out == a >> count and out[0]==1.

Test Plan:
- a=0x0001, left=1, start in cycle 0 -> busy cycles 1..16; done in cycle 17; out=0x8000, count=15, zero=0.
- a=0x8000, left=1 -> done in cycle 2; out=0x8000, count=0. Then a=0x0100, left=0 -> out=0x0001, count=8, done 8+2 cycles after its start.
- a=0x0000, either direction -> done in cycle 2; out=0x0000, count=16, zero=1.
- During a=0x0001 left run, pulse start with a=0xFFFF in cycle 5 -> ignored; result still 0x8000/15. Outputs hold after done until the next completion.
- rst_n low in cycle 6 of a run -> outputs zero at once, no done pulse, state IDLE. New start after release completes normally.
- Random sweep, 1000 operands, both directions -> the invariants above hold and latency equals count+2 (2 for zero).

Source files
------------

// File: rtl/shift_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : shift_normalizer
// Purpose  : Multi-cycle normalizer. Shifts a latched operand one bit per
//            cycle until its leading one (left mode) or trailing one (right
//            mode) reaches the edge, then reports the normalized value and
//            the number of single-bit shifts applied.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            start  - request pulse, sampled only in IDLE
//            left   - 1 = normalize toward MSB, 0 = toward LSB (latched)
//            a      - operand (latched with start)
//            busy   - high while shifting
//            done   - one-cycle completion pulse
//            out    - normalized result
//            count  - number of single-bit shifts applied
//            zero   - operand was all-zero
// Revision : 1.0 - initial release
// ============================================================================
module shift_normalizer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             left,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] c_width_cnt = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_one_cnt   = CNT_W'(1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sreg;
    logic             r_dir;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_out;
    logic [CNT_W-1:0] r_count;
    logic             r_zero;

    logic [1:0]       w_state_nx;
    logic [WIDTH-1:0] w_sreg_nx;
    logic             w_dir_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [WIDTH-1:0] w_out_nx;
    logic [CNT_W-1:0] w_count_nx;
    logic             w_zero_nx;
    logic             w_edge;

    // Bit that must be set for the operand to count as normalized.
    assign w_edge = r_dir ? r_sreg[WIDTH-1] : r_sreg[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_count <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_sreg  <= w_sreg_nx;
            r_dir   <= w_dir_nx;
            r_cnt   <= w_cnt_nx;
            r_out   <= w_out_nx;
            r_count <= w_count_nx;
            r_zero  <= w_zero_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_sreg_nx  = r_sreg;
        w_dir_nx   = r_dir;
        w_cnt_nx   = r_cnt;
        w_out_nx   = r_out;
        w_count_nx = r_count;
        w_zero_nx  = r_zero;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_sreg_nx  = a;
                    w_dir_nx   = left;
                    w_cnt_nx   = '0;
                    w_state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Zero check takes priority: an all-zero operand never
                // produces an edge bit and would otherwise shift forever.
                if (r_sreg == '0) begin
                    w_out_nx   = '0;
                    w_count_nx = c_width_cnt;
                    w_zero_nx  = 1'b1;
                    w_state_nx = S_DONE;
                end else if (w_edge) begin
                    w_out_nx   = r_sreg;
                    w_count_nx = r_cnt;
                    w_zero_nx  = 1'b0;
                    w_state_nx = S_DONE;
                end else begin
                    w_sreg_nx = r_dir ? (r_sreg << 1) : (r_sreg >> 1);
                    // A nonzero operand terminates within WIDTH-1 shifts,
                    // so this increment cannot wrap.
                    w_cnt_nx  = r_cnt + c_one_cnt;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign busy  = (r_state == S_SHIFT);
    assign done  = (r_state == S_DONE);
    assign out   = r_out;
    assign count = r_count;
    assign zero  = r_zero;

endmodule
`default_nettype wire
